start_ctrl: RTL and testbench



---
 rtl/start_ctrl.sv | 168 ++++++++++++++++
 tb/tb_start_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/start_ctrl.sv
// start_ctrl: synchronises lock/button, debounces the button, issues a
// one-cycle filter start pulse, waits for completion or timeout, drives LEDs.
// Ports:
//   clk, rst     - 100 MHz clock, async active-high reset
//   i_locked     - clock-wizard lock flag (async to clk)
//   i_btn_start  - raw start button (async, bouncy)
//   i_done       - filter completion strobe (sampled in RUN only)
//   o_start      - one-cycle start pulse
//   o_busy       - high in START or RUN
//   o_leds       - registered status LEDs
module start_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 1_000_000,
    parameter int LOCK_WAIT_CYCLES = 1024,
    parameter int TIMEOUT_CYCLES   = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_locked,
    input  logic       i_btn_start,
    input  logic       i_done,
    output logic       o_start,
    output logic       o_busy,
    output logic [5:0] o_leds
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOCK_WAIT_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_WAIT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_IDLE,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic          btn_meta, btn_sync;
    logic          lock_meta, lock_sync;
    logic [DW-1:0] db_cnt;
    logic          db_level, db_level_q;
    logic [LW-1:0] lock_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [1:0]    run_cnt;
    logic          err;
    logic          err_set;
    logic          press;
    logic          lock_ok;
    logic          tmo_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            btn_meta  <= i_btn_start;
            btn_sync  <= btn_meta;
            lock_meta <= i_locked;
            lock_sync <= lock_meta;
        end
    end

    // Counter reaching DEBOUNCE_CYCLES is folded into the toggle: the edge
    // that would store DEBOUNCE_CYCLES flips the level and clears instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt     <= '0;
            db_level   <= 1'b0;
            db_level_q <= 1'b0;
        end else begin
            db_level_q <= db_level;
            if (btn_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_cnt   <= '0;
                db_level <= ~db_level;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
        end
    end

    assign press = db_level & ~db_level_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_cnt <= '0;
        end else if (!lock_sync) begin
            lock_cnt <= '0;
        end else if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + LW'(1);
        end
    end

    assign lock_ok = (lock_cnt == LOCK_MAX);
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        unique case (state_q)
            S_WAIT_LOCK: if (lock_ok) state_d = S_IDLE;
            S_IDLE:      if (press) state_d = S_START;
            S_START:     state_d = S_RUN;
            S_RUN: begin
                if (i_done) begin
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    err_set = 1'b1;
                end
            end
            S_DONE:      if (press) state_d = S_START;
            default:     state_d = S_WAIT_LOCK;
        endcase
        // Losing lock overrides every other transition.
        if (!lock_ok) begin
            state_d = S_WAIT_LOCK;
            err_set = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_WAIT_LOCK;
            tmo_cnt <= '0;
            run_cnt <= 2'd0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_START) begin
                tmo_cnt <= '0;
                run_cnt <= run_cnt + 2'd1;
                err     <= 1'b0;
            end else begin
                if (state_q == S_RUN && TIMEOUT_CYCLES != 0)
                    tmo_cnt <= tmo_cnt + TW'(1);
                if (err_set)
                    err <= 1'b1;
            end
        end
    end

    assign o_start = (state_q == S_START);
    assign o_busy  = (state_q == S_START) || (state_q == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_leds <= 6'd0;
        end else begin
            o_leds <= {run_cnt[0],
                       err,
                       (state_q == S_DONE) && !err,
                       o_busy,
                       state_q == S_IDLE,
                       lock_ok};
        end
    end

endmodule

// File: tb/tb_start_ctrl.sv
// tb_start_ctrl: directed bench for start_ctrl with small debounce,
// lock and timeout limits; one task per scenario.
module tb_start_ctrl;

    logic       clk;
    logic       rst;
    logic       i_locked;
    logic       i_btn_start;
    logic       i_done;
    logic       o_start;
    logic       o_busy;
    logic [5:0] o_leds;

    int n_vec;
    int n_bad;
    int n_start;

    start_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .LOCK_WAIT_CYCLES(8),
        .TIMEOUT_CYCLES  (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_locked   (i_locked),
        .i_btn_start(i_btn_start),
        .i_done     (i_done),
        .o_start    (o_start),
        .o_busy     (o_busy),
        .o_leds     (o_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (o_start) n_start++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_start) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_btn();
        i_btn_start = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_locked = 1'b0;
        i_btn_start = 1'b0;
        i_done = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (o_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_start got %b want 0", o_start);
        end
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_busy got %b want 0", o_busy);
        end
        n_vec++;
        if (o_leds !== 6'b000000) begin
            n_bad++;
            $display("FAIL reset_leds got %b want 000000", o_leds);
        end
    endtask

    task automatic test_lock();
        rst = 1'b0;
        i_locked = 1'b1;
        repeat (10) tick();
        n_vec++;
        if (o_leds[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_early got %b want 0", o_leds[0]);
        end
        tick();
        n_vec++;
        if (o_leds[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL lock_edge11 got %b want 1", o_leds[0]);
        end
        tick();
        n_vec++;
        if (o_leds !== 6'b000011) begin
            n_bad++;
            $display("FAIL lock_idle_leds got %b want 000011", o_leds);
        end
    endtask

    task automatic test_press();
        int first;
        int cnt;
        first = -1;
        cnt = 0;
        i_btn_start = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (o_start) begin
                if (first < 0) first = e;
                cnt++;
            end
        end
        n_vec++;
        if (first !== 6) begin
            n_bad++;
            $display("FAIL press_latency got %0d want 6", first);
        end
        n_vec++;
        if (cnt !== 1) begin
            n_bad++;
            $display("FAIL press_width got %0d want 1", cnt);
        end
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL press_busy got %b want 1", o_busy);
        end
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        tick();
        n_vec++;
        if (o_leds !== 6'b101001) begin
            n_bad++;
            $display("FAIL press_done_leds got %b want 101001", o_leds);
        end
        n_vec++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL press_done_busy got %b want 0", o_busy);
        end
        release_btn();
    endtask

    task automatic test_bounce();
        int s0;
        s0 = n_start;
        for (int i = 0; i < 20; i++) begin
            i_btn_start = ~i_btn_start;
            tick();
            tick();
        end
        i_btn_start = 1'b0;
        repeat (8) tick();
        n_vec++;
        if (n_start - s0 !== 0) begin
            n_bad++;
            $display("FAIL bounce_starts got %0d want 0", n_start - s0);
        end
        n_vec++;
        if (o_leds !== 6'b101001) begin
            n_bad++;
            $display("FAIL bounce_leds got %b want 101001", o_leds);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int n;
        i_btn_start = 1'b1;
        wait_start(seen);
        n_vec++;
        if (seen !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_start got %b want 1", seen);
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (!o_busy) break;
            n++;
        end
        n_vec++;
        if (n !== 20) begin
            n_bad++;
            $display("FAIL tmo_run_cycles got %0d want 20", n);
        end
        tick();
        n_vec++;
        if (o_leds !== 6'b010001) begin
            n_bad++;
            $display("FAIL tmo_err_leds got %b want 010001", o_leds);
        end
        release_btn();
        n_vec++;
        if (o_leds[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_err_hold got %b want 1", o_leds[4]);
        end
        i_btn_start = 1'b1;
        wait_start(seen);
        n_vec++;
        if (seen !== 1'b1) begin
            n_bad++;
            $display("FAIL tmo_restart got %b want 1", seen);
        end
        tick();
        tick();
        n_vec++;
        if (o_leds !== 6'b100101) begin
            n_bad++;
            $display("FAIL tmo_err_clear got %b want 100101", o_leds);
        end
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        tick();
        n_vec++;
        if (o_leds !== 6'b101001) begin
            n_bad++;
            $display("FAIL tmo_rerun_done got %b want 101001", o_leds);
        end
        release_btn();
    endtask

    task automatic test_run_press();
        bit seen;
        int s0;
        s0 = n_start;
        i_btn_start = 1'b1;
        wait_start(seen);
        i_btn_start = 1'b0;
        repeat (8) tick();
        i_btn_start = 1'b1;
        repeat (8) tick();
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL runpress_busy got %b want 1", o_busy);
        end
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        tick();
        n_vec++;
        if (o_leds !== 6'b001001) begin
            n_bad++;
            $display("FAIL runpress_leds got %b want 001001", o_leds);
        end
        repeat (4) tick();
        n_vec++;
        if (n_start - s0 !== 1) begin
            n_bad++;
            $display("FAIL runpress_starts got %0d want 1", n_start - s0);
        end
        release_btn();
    endtask

    task automatic test_lock_drop();
        bit seen;
        int n;
        i_btn_start = 1'b1;
        wait_start(seen);
        i_btn_start = 1'b0;
        repeat (3) tick();
        i_locked = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n++;
            if (!o_busy) break;
        end
        n_vec++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL lockdrop_edges got %0d want 4", n);
        end
        tick();
        n_vec++;
        if (o_leds !== 6'b100000) begin
            n_bad++;
            $display("FAIL lockdrop_leds got %b want 100000", o_leds);
        end
        repeat (4) tick();
    endtask

    task automatic test_idle_done();
        int s0;
        int n;
        i_locked = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (o_leds[1]) break;
            n++;
        end
        n_vec++;
        if (o_leds !== 6'b100011) begin
            n_bad++;
            $display("FAIL relock_leds got %b want 100011 after %0d", o_leds, n);
        end
        s0 = n_start;
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (o_leds !== 6'b100011) begin
            n_bad++;
            $display("FAIL idledone_leds got %b want 100011", o_leds);
        end
        n_vec++;
        if (n_start - s0 !== 0) begin
            n_bad++;
            $display("FAIL idledone_starts got %0d want 0", n_start - s0);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        i_btn_start = 1'b1;
        wait_start(seen);
        i_btn_start = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_busy got %b want 1", o_busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({o_start, o_busy, o_leds} !== 8'd0) begin
            n_bad++;
            $display("FAIL midrun_reset got %b%b%b want all 0",
                     o_start, o_busy, o_leds);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        n_start = 0;
        test_reset();
        test_lock();
        test_press();
        test_bounce();
        test_timeout();
        test_run_press();
        test_lock_drop();
        test_idle_done();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
